reset_seq: RTL and testbench



---
 rtl/reset_seq_pkg.sv | 21 ++
 rtl/rst_prio_enc.sv | 23 ++
 rtl/reset_seq.sv | 115 +++++++++++
 tb/tb_reset_seq.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and elaboration helpers for the reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // Phase counter must reach max(hold, gap)-1.
  function automatic int phase_w(int hold, int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    return $clog2(m + 1);
  endfunction

  function automatic bit timing_ok(int hold, int gap);
    return (hold >= 1) && (gap >= 1);
  endfunction

endpackage

// File: rtl/rst_prio_enc.sv
// Lowest-set-bit finder: returns the index of the lowest request and a valid flag.
module rst_prio_enc #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          vld
);

  // Scanning high to low lets the lowest set bit overwrite last.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IW'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reset_seq.sv
// Reset sequencer: trigger edges select domains via masks; selected domains
// are reset one at a time in ascending order with a fixed hold and gap.
module reset_seq
  import reset_seq_pkg::*;
#(
  parameter int N_SRC       = 2,
  parameter int N_DOM       = 2,
  parameter int HOLD_CYCLES = 60,
  parameter int GAP_CYCLES  = 5,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   sys_res_n,
  input  logic [N_SRC-1:0]       trig,
  input  logic [N_SRC*N_DOM-1:0] src_mask,
  input  logic                   cause_clr,
  output logic [N_DOM-1:0]       dom_res_n,
  output logic                   busy,
  output logic [N_SRC-1:0]       cause,
  output logic [CNT_W-1:0]       rst_count
);

  localparam int PW = phase_w(HOLD_CYCLES, GAP_CYCLES);
  localparam int IW = (N_DOM > 1) ? $clog2(N_DOM) : 1;

  if (!timing_ok(HOLD_CYCLES, GAP_CYCLES)) begin : g_bad_cfg
    $error("reset_seq: HOLD_CYCLES and GAP_CYCLES must both be >= 1");
  end

  state_t           state, state_nx;
  logic [PW-1:0]    phase;
  logic [IW-1:0]    cur, cur_nx, lo_idx;
  logic             lo_vld, take, start;
  logic [N_SRC-1:0] trig_q, ev;
  logic [N_DOM-1:0] new_bits, pend, pend_all, pend_nx;
  logic [N_DOM-1:0] dom_res_n_d;
  logic             busy_d;

  assign ev = trig & ~trig_q;

  always_comb begin
    new_bits = '0;
    for (int s = 0; s < N_SRC; s++)
      if (ev[s]) new_bits = new_bits | src_mask[s*N_DOM +: N_DOM];
  end

  // Same-cycle events are visible to the FSM so the first hold starts at the edge.
  assign pend_all = pend | new_bits;

  rst_prio_enc #(.N(N_DOM), .IW(IW)) u_enc (
    .req (pend_all),
    .idx (lo_idx),
    .vld (lo_vld)
  );

  // Next state
  always_comb begin
    state_nx = state;
    cur_nx   = cur;
    pend_nx  = pend_all;
    take     = 1'b0;
    case (state)
      S_IDLE: take = lo_vld;
      S_HOLD: if (phase == PW'(HOLD_CYCLES - 1)) state_nx = S_GAP;
      S_GAP: begin
        if (phase == PW'(GAP_CYCLES - 1)) begin
          if (lo_vld) take = 1'b1;
          else        state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (take) begin
      state_nx = S_HOLD;
      cur_nx   = lo_idx;
      for (int d = 0; d < N_DOM; d++)
        if (IW'(d) == lo_idx) pend_nx[d] = 1'b0;
    end
  end

  assign start = take && (state == S_IDLE);

  // Outputs are decoded from the next state and registered below.
  always_comb begin
    dom_res_n_d = '1;
    busy_d      = (state_nx != S_IDLE);
    if (state_nx == S_HOLD) dom_res_n_d[cur_nx] = 1'b0;
  end

  always_ff @(posedge clk or negedge sys_res_n) begin
    if (!sys_res_n) begin
      state     <= S_IDLE;
      phase     <= '0;
      cur       <= '0;
      pend      <= '0;
      trig_q    <= '0;
      cause     <= '0;
      rst_count <= '0;
      dom_res_n <= '1;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      cur       <= cur_nx;
      pend      <= pend_nx;
      trig_q    <= trig;
      cause     <= (cause & ~{N_SRC{cause_clr}}) | ev;
      dom_res_n <= dom_res_n_d;
      busy      <= busy_d;
      if (state_nx != state || state == S_IDLE) phase <= '0;
      else                                      phase <= phase + PW'(1);
      if (start && rst_count != {CNT_W{1'b1}}) rst_count <= rst_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_reset_seq.sv
// Scoreboard bench for reset_seq: stimulus queues expected output changes,
// a negedge monitor pops and checks them whenever dom_res_n/busy change.
module tb_reset_seq;

  logic       clk = 1'b0;
  logic       sys_res_n;
  logic [1:0] trig;
  logic [3:0] src_mask;
  logic       cause_clr;
  logic [1:0] dom_res_n;
  logic       busy;
  logic [1:0] cause;
  logic [7:0] rst_count;

  reset_seq #(
    .N_SRC(2), .N_DOM(2), .HOLD_CYCLES(60), .GAP_CYCLES(5), .CNT_W(8)
  ) dut (
    .clk       (clk),
    .sys_res_n (sys_res_n),
    .trig      (trig),
    .src_mask  (src_mask),
    .cause_clr (cause_clr),
    .dom_res_n (dom_res_n),
    .busy      (busy),
    .cause     (cause),
    .rst_count (rst_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [1:0] dom;
    logic       bsy;
    int         cnt;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;
  logic [2:0] last = 3'b110;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(int at, logic [1:0] dom, logic bsy, int cnt);
    exp_t e;
    e.at = at; e.dom = dom; e.bsy = bsy; e.cnt = cnt;
    q.push_back(e);
  endtask

  // Inputs change 2ns after the rising edge; cyc then equals edges seen so far.
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Standard two-domain sequence starting at edge c+1.
  task automatic push_two(int c, int cnt);
    push(c + 1,   2'b10, 1'b1, cnt);
    push(c + 61,  2'b11, 1'b1, cnt);
    push(c + 66,  2'b01, 1'b1, cnt);
    push(c + 126, 2'b11, 1'b1, cnt);
    push(c + 131, 2'b11, 1'b0, cnt);
  endtask

  always @(negedge clk) begin
    if (mon_en && {dom_res_n, busy} !== last) begin
      if (q.size() == 0) begin
        chk("unexpected_change", {29'd0, dom_res_n, busy}, {29'd0, last});
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("evt_cycle", cyc, e.at);
        chk("evt_dom_res_n", {30'd0, dom_res_n}, {30'd0, e.dom});
        chk("evt_busy", {31'd0, busy}, {31'd0, e.bsy});
        chk("evt_rst_count", {24'd0, rst_count}, e.cnt);
      end
      last = {dom_res_n, busy};
    end
  end

  int c;

  initial begin
    sys_res_n = 1'b0;
    trig      = 2'b00;
    src_mask  = 4'b10_11;
    cause_clr = 1'b0;
    step(3);
    chk("reset_dom_res_n", {30'd0, dom_res_n}, 32'd3);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_cause", {30'd0, cause}, 32'd0);
    chk("reset_count", {24'd0, rst_count}, 32'd0);
    sys_res_n = 1'b1;
    step(2);
    mon_en = 1'b1;

    // Two-domain sequence from source 0
    c = cyc;
    push_two(c, 1);
    trig[0] = 1'b1;
    step(1);
    chk("t1_cause_at_edge", {30'd0, cause}, 32'd1);
    chk("t1_count_at_edge", {24'd0, rst_count}, 32'd1);
    step(9);
    trig[0] = 1'b0;
    step(130);
    chk("t1_cause", {30'd0, cause}, 32'd1);
    chk("t1_count", {24'd0, rst_count}, 32'd1);
    chk("t1_q_empty", q.size(), 0);

    // Source 1 re-requests an already pending domain during hold of domain 0
    cause_clr = 1'b1;
    step(1);
    cause_clr = 1'b0;
    chk("t3_cause_cleared", {30'd0, cause}, 32'd0);
    c = cyc;
    push_two(c, 2);
    trig[0] = 1'b1;
    step(30);
    trig[1] = 1'b1;
    step(1);
    chk("t3_cause_both", {30'd0, cause}, 32'd3);
    step(110);
    trig = 2'b00;
    step(5);
    chk("t3_count", {24'd0, rst_count}, 32'd2);
    chk("t3_q_empty", q.size(), 0);

    // Source 1 held high for 500 cycles gives exactly one sequence
    c = cyc;
    push(c + 1,  2'b01, 1'b1, 3);
    push(c + 61, 2'b11, 1'b1, 3);
    push(c + 66, 2'b11, 1'b0, 3);
    trig[1] = 1'b1;
    step(500);
    trig[1] = 1'b0;
    step(2);
    chk("t2_count", {24'd0, rst_count}, 32'd3);
    chk("t2_q_empty", q.size(), 0);

    // Asynchronous reset mid-hold abandons the sequence
    c = cyc;
    push(c + 1, 2'b10, 1'b1, 4);
    trig[0] = 1'b1;
    step(30);
    push(c + 31, 2'b11, 1'b0, 0);
    step(1);
    sys_res_n = 1'b0;
    #1;
    chk("t4_async_dom", {30'd0, dom_res_n}, 32'd3);
    chk("t4_async_cause", {30'd0, cause}, 32'd0);
    chk("t4_async_count", {24'd0, rst_count}, 32'd0);
    trig[0] = 1'b0;
    step(3);
    sys_res_n = 1'b1;
    step(200);
    chk("t4_no_resume_busy", {31'd0, busy}, 32'd0);
    chk("t4_count", {24'd0, rst_count}, 32'd0);
    chk("t4_q_empty", q.size(), 0);

    // Empty mask: cause only; set beats clear in the same cycle
    src_mask = 4'b10_00;
    trig[0] = 1'b1;
    step(1);
    chk("t5_cause_set", {30'd0, cause}, 32'd1);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_dom", {30'd0, dom_res_n}, 32'd3);
    trig[0] = 1'b0;
    step(2);
    cause_clr = 1'b1;
    step(1);
    cause_clr = 1'b0;
    chk("t5_cause_clr", {30'd0, cause}, 32'd0);
    cause_clr = 1'b1;
    trig[0]   = 1'b1;
    step(1);
    cause_clr = 1'b0;
    trig[0]   = 1'b0;
    chk("t5_set_wins", {30'd0, cause}, 32'd1);
    step(3);
    chk("t5_count", {24'd0, rst_count}, 32'd0);
    chk("t5_q_empty", q.size(), 0);

    // 300 back-to-back single-domain sequences saturate the counter
    src_mask = 4'b00_01;
    for (int i = 0; i < 300; i++) begin
      int n;
      n = (i + 1 > 255) ? 255 : i + 1;
      c = cyc;
      push(c + 1,  2'b10, 1'b1, n);
      push(c + 61, 2'b11, 1'b1, n);
      push(c + 66, 2'b11, 1'b0, n);
      trig[0] = 1'b1;
      step(1);
      trig[0] = 1'b0;
      step(65);
    end
    step(3);
    chk("t6_count_sat", {24'd0, rst_count}, 32'd255);
    chk("t6_q_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
